alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: port 0 (execute stage) and port 1 (branch/address unit or a multi-cycle helper).
- Registers operands and opcode, drives the ALU for one cycle, and captures the result and the Z/N/C/O flags.
- Returns the result on a shared response channel tagged with the requester id.
- Arbitration is round-robin, with valid/ready handshakes on both the request and response sides.

---
 rtl/alu_arbiter_if.sv | 62 ++++++
 rtl/alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the two request channels and the shared response channel of the
//   ALU arbiter. Each channel uses a valid/ready handshake.
//
//   Request channel N (N = 0, 1):
//     reqN_valid  requester -> arbiter  an operation is offered
//     reqN_ready  arbiter -> requester  operation accepted this cycle
//     reqN_a      requester -> arbiter  operand 1
//     reqN_b      requester -> arbiter  operand 2
//     reqN_op     requester -> arbiter  ALUControl code
//   Response channel:
//     rsp_valid   arbiter -> consumer   response available
//     rsp_ready   consumer -> arbiter   consumer takes the response
//     rsp_id      arbiter -> consumer   requester that owns the response
//     rsp_result  arbiter -> consumer   captured ALU result
//     rsp_flags   arbiter -> consumer   captured {Z,N,C,O}
//     rsp_err     arbiter -> consumer   illegal opcode indication
//
//   Modports: slave = arbiter side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters (0: execute stage,
//   1: branch/address unit). A winning request is registered onto the ALU
//   inputs, the ALU gets exactly one cycle to settle, and the result plus
//   Z/N/C/O flags are captured and returned on a shared response channel
//   tagged with the owner id. Contention is resolved round-robin; the
//   pointer only moves when a request is actually accepted.
//
//   Timing: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold until taken).
//   Best case one operation every three cycles.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     bus        slave modport of alu_arbiter_if (requests + response)
//     alu_data1  out  registered ALU operand 1
//     alu_data2  out  registered ALU operand 2
//     alu_ctrl   out  registered ALU control code
//     alu_result in   ALU result
//     alu_z/n/c/o in  ALU flags
//
//   Optional feature macro: ALU_ARB_OPCHECK_EN
//     When defined, an accepted opcode outside the ten legal codes still runs
//     with normal timing, but the ALU is driven with ADD and the response
//     reports result 0, flags 0, rsp_err 1. When undefined, opcodes pass
//     through unchecked and rsp_err is constant 0.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [OPW-1:0]   alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state_r;
  state_t state_s;

  // Round-robin pointer: 0 favours requester 0, 1 favours requester 1.
  logic ptr_r;
  // Id of the requester whose operation is in flight.
  logic owner_r;

  logic grant0_s;
  logic grant1_s;
  logic accept_s;
  logic winner_s;
  logic rsp_take_s;

  logic [WIDTH-1:0] win_a_s;
  logic [WIDTH-1:0] win_b_s;
  logic [OPW-1:0]   win_op_s;
  logic [OPW-1:0]   win_ctrl_s;

  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic [3:0]       rsp_flags_r;

`ifdef ALU_ARB_OPCHECK_EN
  localparam logic [OPW-1:0] OP_ADD  = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_AND  = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_OR   = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(4'b1101);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(4'b0011);

  // True for the ten codes the ALU implements.
  function automatic logic op_legal(input logic [OPW-1:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU: ok = 1'b1;
      default:                                 ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic win_bad_s;
  logic bad_r;
  logic rsp_err_r;
`endif

  // Grant selection: a lone valid requester wins, a tie goes to the pointer.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0_s = ~ptr_r;
      grant1_s = ptr_r;
    end else begin
      grant0_s = bus.req0_valid;
      grant1_s = bus.req1_valid;
    end
  end

  // Ready is gated by rst_n so both readies read 0 while reset is held.
  assign bus.req0_ready = rst_n & (state_r == IDLE) & grant0_s;
  assign bus.req1_ready = rst_n & (state_r == IDLE) & grant1_s;

  assign accept_s   = (state_r == IDLE) & (grant0_s | grant1_s);
  assign winner_s   = grant1_s;
  assign rsp_take_s = rsp_valid_r & bus.rsp_ready;

  // Winning request payload mux.
  always_comb begin
    win_a_s  = bus.req0_a;
    win_b_s  = bus.req0_b;
    win_op_s = bus.req0_op;
    if (winner_s) begin
      win_a_s  = bus.req1_a;
      win_b_s  = bus.req1_b;
      win_op_s = bus.req1_op;
    end else begin
      win_a_s  = bus.req0_a;
      win_b_s  = bus.req0_b;
      win_op_s = bus.req0_op;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Illegal opcodes are replaced by ADD on the ALU control lines.
  always_comb begin
    win_bad_s  = ~op_legal(win_op_s);
    win_ctrl_s = win_op_s;
    if (win_bad_s) begin
      win_ctrl_s = {OPW{1'b0}};
    end else begin
      win_ctrl_s = win_op_s;
    end
  end
`else
  assign win_ctrl_s = win_op_s;
`endif

  // Next-state logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
      end
      RESP: begin
        if (rsp_take_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue registers: ALU operands/control, owner id and round-robin pointer.
  // The ALU inputs hold their last value outside EXEC on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_data1 <= {WIDTH{1'b0}};
      alu_data2 <= {WIDTH{1'b0}};
      alu_ctrl  <= {OPW{1'b0}};
      owner_r   <= 1'b0;
      ptr_r     <= 1'b0;
    end else if (accept_s) begin
      alu_data1 <= win_a_s;
      alu_data2 <= win_b_s;
      alu_ctrl  <= win_ctrl_s;
      owner_r   <= winner_s;
      ptr_r     <= ~winner_s;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Remembers whether the in-flight opcode was illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_r <= 1'b0;
    end else if (accept_s) begin
      bad_r <= win_bad_s;
    end
  end
`endif

  // Response registers: captured only on the EXEC->RESP edge, cleared on take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_flags_r  <= 4'b0000;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_r    <= 1'b0;
`endif
    end else if (state_r == EXEC) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= owner_r;
`ifdef ALU_ARB_OPCHECK_EN
      if (bad_r) begin
        rsp_result_r <= {WIDTH{1'b0}};
        rsp_flags_r  <= 4'b0000;
        rsp_err_r    <= 1'b1;
      end else begin
        rsp_result_r <= alu_result;
        rsp_flags_r  <= {alu_z, alu_n, alu_c, alu_o};
        rsp_err_r    <= 1'b0;
      end
`else
      rsp_result_r <= alu_result;
      rsp_flags_r  <= {alu_z, alu_n, alu_c, alu_o};
`endif
    end else if (rsp_take_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flags  = rsp_flags_r;
`ifdef ALU_ARB_OPCHECK_EN
  assign bus.rsp_err    = rsp_err_r;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Two requester drivers feed the arbiter from per-port queues, a consumer
//   drives rsp_ready, and a behavioural ALU closes the loop. Accepted requests
//   are predicted from the round-robin rule and pushed to a scoreboard; a
//   monitor pops and compares each response. Directed cases are followed by
//   a randomized phase.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 4;
`ifdef ALU_ARB_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b1001, AND = 4'b0111, OR = 4'b0110,
                         XOR = 4'b0100, SLL = 4'b0001, SRL = 4'b0101, SRA = 4'b1101,
                         SLT = 4'b0010, SLTU = 4'b0011;

  typedef struct packed { logic [31:0] res; logic [3:0] flags; } alu_out_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; } req_t;
  typedef struct { logic id; logic [31:0] res; logic [3:0] flags; logic err; int hs; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  logic [WIDTH-1:0] alu_data1, alu_data2, alu_result;
  logic [OPW-1:0]   alu_ctrl;
  logic             alu_z, alu_n, alu_c, alu_o;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rr_mode = 0;   // 0: always ready, 1: stalled, 2: random
  int gap_pct = 0;   // chance (percent) a driver idles instead of issuing
  req_t q0[$];
  req_t q1[$];
  exp_t sbq[$];
  logic cur_v = 1'b0;
  exp_t cur;
  logic [3:0] legal_ops [10] = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU, straight from the opcode definitions.
  function automatic alu_out_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic c, o;
    alu_out_t out;
    c = 1'b0; o = 1'b0; r = 32'd0; w = 33'd0;
    case (op)
      ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                  o = (a[31] == b[31]) && (r[31] != a[31]); end
      SUB:  begin r = a - b; c = (a >= b); o = (a[31] != b[31]) && (r[31] != a[31]); end
      AND:  r = a & b;
      OR:   r = a | b;
      XOR:  r = a ^ b;
      SLL:  r = a << b[4:0];
      SRL:  r = a >> b[4:0];
      SRA:  r = 32'($signed(a) >>> b[4:0]);
      SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    out.res = r;
    out.flags = {(r == 32'd0), r[31], c, o};
    return out;
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU};
  endfunction

  // Environment ALU; output is scrambled while a response is held so any
  // late re-sampling by the arbiter shows up as a wrong result.
  alu_out_t env_s;
  always_comb begin
    env_s = alu_ref(alu_data1, alu_data2, alu_ctrl);
    alu_result = env_s.res ^ (bus.rsp_valid ? 32'hA5A5_5A5A : 32'h0000_0000);
    {alu_z, alu_n, alu_c, alu_o} = env_s.flags ^ (bus.rsp_valid ? 4'hF : 4'h0);
  end

  task automatic push_req(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req_t r;
    r.a = a; r.b = b; r.op = op;
    if (port == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Requester 0 driver.
  initial begin : drv0
    logic taken;
    req_t s;
    bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_op = 4'd0;
    forever begin
      @(negedge clk);
      taken = bus.req0_valid && bus.req0_ready;
      @(posedge clk); #1;
      if (taken || !bus.req0_valid) begin
        if (q0.size() != 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
          s = q0.pop_front();
          bus.req0_a = s.a; bus.req0_b = s.b; bus.req0_op = s.op; bus.req0_valid = 1'b1;
        end else begin
          bus.req0_valid = 1'b0;
        end
      end
    end
  end

  // Requester 1 driver.
  initial begin : drv1
    logic taken;
    req_t s;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 4'd0;
    forever begin
      @(negedge clk);
      taken = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (taken || !bus.req1_valid) begin
        if (q1.size() != 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
          s = q1.pop_front();
          bus.req1_a = s.a; bus.req1_b = s.b; bus.req1_op = s.op; bus.req1_valid = 1'b1;
        end else begin
          bus.req1_valid = 1'b0;
        end
      end
    end
  end

  // Response consumer.
  initial begin : consumer
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'b0;
        default: bus.rsp_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: predicts grants, fills the scoreboard, checks responses.
  initial begin : monitor
    logic mbusy, mptr, e0, e1;
    logic [31:0] ea, eb;
    logic [3:0] eo;
    exp_t e;
    alu_out_t r;
    mbusy = 1'b0; mptr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete(); mbusy = 1'b0; mptr = 1'b0; cur_v = 1'b0;
      end else begin
        e0 = !mbusy && bus.req0_valid && (!bus.req1_valid || !mptr);
        e1 = !mbusy && bus.req1_valid && (!bus.req0_valid || mptr);
        check("req0_ready", 64'(bus.req0_ready), 64'(e0));
        check("req1_ready", 64'(bus.req1_ready), 64'(e1));
        if (e0 || e1) begin
          if (e1) begin ea = bus.req1_a; eb = bus.req1_b; eo = bus.req1_op; end
          else begin ea = bus.req0_a; eb = bus.req0_b; eo = bus.req0_op; end
          e.id = e1;
          e.hs = cyc;
          if (OPCHECK && !is_legal(eo)) begin
            e.res = 32'd0; e.flags = 4'd0; e.err = 1'b1;
          end else begin
            r = alu_ref(ea, eb, eo);
            e.res = r.res; e.flags = r.flags; e.err = 1'b0;
          end
          sbq.push_back(e);
          mptr = ~e1;
          mbusy = 1'b1;
        end
        if (bus.rsp_valid) begin
          if (!cur_v) begin
            if (sbq.size() == 0) begin
              check("spurious_rsp", 64'(bus.rsp_valid), 64'd0);
            end else begin
              cur = sbq.pop_front();
              cur_v = 1'b1;
              check("rsp_latency", 64'(cyc - cur.hs), 64'd2);
            end
          end
          if (cur_v) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(cur.id));
            check("rsp_result", 64'(bus.rsp_result), 64'(cur.res));
            check("rsp_flags", 64'(bus.rsp_flags), 64'(cur.flags));
            check("rsp_err", 64'(bus.rsp_err), 64'(cur.err));
          end
          if (bus.rsp_ready) begin
            cur_v = 1'b0;
            mbusy = 1'b0;
          end
        end
      end
    end
  end

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.req0_valid || bus.req1_valid ||
            sbq.size() != 0 || cur_v) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < max_cyc), 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(5, 0))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(31, 0));
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rnd_op();
    if ($urandom_range(11, 0) == 0) return 4'($urandom_range(15, 0));
    return legal_ops[$urandom_range(9, 0)];
  endfunction

  initial begin : main
    int n;
    logic hs;
    // Reset with both requesters already pending.
    push_req(0, 32'd5, 32'd7, ADD);
    push_req(1, 32'd5, 32'd2, SLL);
    repeat (3) @(posedge clk);
    #2;
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
    check("rst_alu_data1", 64'(alu_data1), 64'd0);
    check("rst_alu_data2", 64'(alu_data2), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'(ADD));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    check("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    rst_n = 1'b1;
    // Further contended pairs: grants must keep alternating.
    push_req(0, 32'd1, 32'd2, ADD);
    push_req(1, 32'd3, 32'd4, SLL);
    push_req(0, 32'd9, 32'd1, SUB);
    push_req(1, 32'hF0F0_0000, 32'h0FF0_FF00, XOR);
    drain(200);

    // Single request on port 0, then hold-value check of the ALU inputs.
    push_req(0, 32'd10, 32'd3, SUB);
    drain(100);
    check("hold_alu_data1", 64'(alu_data1), 64'd10);
    check("hold_alu_data2", 64'(alu_data2), 64'd3);
    check("hold_alu_ctrl", 64'(alu_ctrl), 64'(SUB));

    // Signed vs unsigned compare on port 1.
    push_req(1, 32'hFFFF_FFFB, 32'd7, SLTU);
    push_req(1, 32'hFFFF_FFFB, 32'd7, SLT);
    drain(100);

    // Backpressure: response held while a second request waits.
    rr_mode = 1;
    push_req(0, 32'd5, 32'd3, XOR);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_rsp_seen", 64'(bus.rsp_valid), 64'd1);
    push_req(1, 32'd8, 32'd8, ADD);
    repeat (5) @(negedge clk);
    check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_hold_result", 64'(bus.rsp_result), 64'd6);
    check("bp_req1_waiting", 64'(bus.req1_valid && !bus.req1_ready), 64'd1);
    rr_mode = 0;
    drain(100);

    // Reset during EXEC: operation is dropped, outputs clear immediately.
    push_req(0, 32'd5, 32'd3, AND);
    n = 0; hs = 1'b0;
    while (!hs && n < 50) begin @(negedge clk); hs = bus.req0_valid && bus.req0_ready; n++; end
    check("midrst_hs_seen", 64'(hs), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_alu_data1", 64'(alu_data1), 64'd0);
    check("midrst_alu_data2", 64'(alu_data2), 64'd0);
    check("midrst_alu_ctrl", 64'(alu_ctrl), 64'(ADD));
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_req0_ready", 64'(bus.req0_ready), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_req(0, 32'd5, 32'd3, OR);
    drain(100);

    // Code outside the legal set.
    push_req(0, 32'd5, 32'd3, 4'b1111);
    push_req(1, 32'd6, 32'd2, 4'b1000);
    drain(100);

    // Randomized traffic with random gaps and random backpressure.
    rr_mode = 2;
    gap_pct = 25;
    for (int i = 0; i < 160; i++) begin
      push_req(int'($urandom_range(1, 0)), rnd_opnd(), rnd_opnd(), rnd_op());
    end
    drain(6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
